// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Operands enter on a valid/ready start port, the result leaves on a valid/ready result port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for operands, start_ready=1
// S_SHIFT | one bit per clock through the full adder, cnt = bit index
// S_DONE  | result presented with sum_valid=1 until sum_ready
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic             s_bit;
    logic             c_next;

    always_comb begin
        s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
        c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                        a_sr  <= a;
                        b_sr  <= op_sub ? ~b : b;
                        carry <= op_sub ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    carry <= c_next;
                    sum_r <= {s_bit, sum_r[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // At the MSB, carry holds the carry-in, c_next the carry-out.
                        cout_r <= c_next;
                        ovf_r  <= carry ^ c_next;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (sum_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign start_ready = (state == S_IDLE);
    assign sum_valid   = (state == S_DONE);
    assign busy        = (state == S_SHIFT) || (state == S_DONE);
    assign sum         = sum_r;
    assign cout        = cout_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): directed cases plus 1000 random operations,
// with a scoreboard queue filled by the driver and drained by a result monitor.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         sum_valid;
    logic         sum_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    serial_adder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .op_sub      (op_sub),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .sum         (sum),
        .cout        (cout),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stall_force = 0;
    bit rand_ready = 0;
    int last_consume = -1;
    bit done_flag = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed readings of a and b.
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic ci, input logic sub);
        exp_t e;
        int ua, ub, tot, sa, sb, sres;
        ua = int'(ai);
        ub = int'(bi);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (sub) begin
            tot  = ua + (255 - ub) + 1;
            sres = sa - sb;
        end else begin
            tot  = ua + ub + int'(ci);
            sres = sa + sb + int'(ci);
        end
        e.sum     = tot[W-1:0];
        e.cout    = (tot > 255);
        e.ovf     = (sres > 127) || (sres < -128);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Entered and left on a negedge; returns the cycle of the accepting edge.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic ci, input logic sub, output int acc);
        int guard;
        exp_t e;
        guard = 0;
        a = ai; b = bi; cin = ci; op_sub = sub; start_valid = 1'b1;
        while (!start_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!start_ready) begin
            chk("start_accept_timeout", 1, 0);
            start_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        e = model(ai, bi, ci, sub);
        e.acc_cyc = acc;
        exp_q.push_back(e);
        start_valid = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom; op_sub = $urandom;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) chk("wait_idle_timeout", 1, 0);
    endtask

    // Result monitor: pops the scoreboard on each newly presented result, then
    // checks the result is held steady and start is blocked while it waits.
    initial begin
        bit checked;
        bit consumed_prev;
        exp_t e;
        logic [W-1:0] h_sum;
        logic h_cout, h_ovf;
        checked = 0;
        consumed_prev = 0;
        h_sum = '0; h_cout = 0; h_ovf = 0;
        sum_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checked = 0;
                consumed_prev = 0;
            end else begin
                if (consumed_prev) checked = 0;
                if (sum_valid) begin
                    if (!checked) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("sum", sum, e.sum);
                            chk("cout", cout, e.cout);
                            chk("overflow", overflow, e.ovf);
                            chk("latency", cyc - e.acc_cyc, W);
                        end
                        h_sum = sum; h_cout = cout; h_ovf = overflow;
                        checked = 1;
                    end else begin
                        chk("hold_sum", sum, h_sum);
                        chk("hold_cout_ovf", {cout, overflow}, {h_cout, h_ovf});
                        chk("hold_start_ready", start_ready, 0);
                    end
                end
                if (stall_force > 0 && sum_valid) begin
                    sum_ready = 1'b0;
                    stall_force--;
                end else if (rand_ready) begin
                    sum_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    sum_ready = 1'b1;
                end
                consumed_prev = sum_valid && sum_ready;
                if (consumed_prev) last_consume = cyc + 1;
            end
        end
    end

    initial begin
        #600000;
        if (!done_flag) begin
            chk("global_timeout", 1, 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        int acc1, acc2;
        bit seen;
        rst_n = 1'b0; start_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout_ovf", {cout, overflow}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h0F, 8'h01, 1'b0, 1'b0, acc1);
        wait_idle();
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, acc1);
        wait_idle();
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, acc1);
        wait_idle();
        do_op(8'h05, 8'h07, 1'b1, 1'b1, acc1);
        wait_idle();
        do_op(8'h05, 8'h07, 1'b0, 1'b1, acc1);
        wait_idle();
        do_op(8'h80, 8'h01, 1'b0, 1'b1, acc1);
        wait_idle();

        // Backpressure: second op waits with start_valid high through the stall.
        stall_force = 5;
        do_op(8'h3C, 8'hC4, 1'b1, 1'b0, acc1);
        do_op(8'h12, 8'h34, 1'b0, 1'b1, acc2);
        chk("accept_after_release", acc2, last_consume + 1);
        wait_idle();

        // Reset during the third SHIFT cycle aborts the operation.
        do_op(8'hAA, 8'h55, 1'b0, 1'b0, acc1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        chk("abort_start_ready", start_ready, 1);
        chk("abort_sum", sum, 0);
        chk("abort_busy", busy, 0);
        seen = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (sum_valid) seen = 1;
        end
        chk("abort_no_result", seen, 0);

        rand_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            do_op($urandom, $urandom, $urandom, $urandom, acc1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        rand_ready = 0;
        chk("scoreboard_empty", exp_q.size(), 0);

        done_flag = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
